// File: rtl/led_trail_pwm.sv
// LED comet-trail driver: lit pattern bits go to full brightness,
// dropped bits fade out through a PWM brightness ramp.
module led_trail_pwm #(
  parameter int N_LEDS     = 8,
  parameter int PWM_BITS   = 4,
  parameter int DECAY_DIV  = 250000,
  parameter int DECAY_STEP = 2
) (
  input  logic              clk,
  input  logic              btn,
  input  logic [N_LEDS-1:0] led_in,
  output logic [N_LEDS-1:0] led_out,
  output logic              frame_tick
);

  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAX   = '1;
  localparam logic [PWM_BITS-1:0] STEP  = PWM_BITS'(DECAY_STEP);
  localparam logic [PWM_BITS-1:0] P_ONE = PWM_BITS'(1);
  localparam logic [DW-1:0]       D_ONE = DW'(1);
  localparam logic [DW-1:0]       DLAST = DW'(DECAY_DIV - 1);

  logic [N_LEDS-1:0]   led_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       decay_cnt;
  logic                decay_tick;
  logic [PWM_BITS-1:0] bright [N_LEDS];

  assign decay_tick = (decay_cnt == DLAST);

  always_ff @(posedge clk) begin
    if (btn) begin
      led_q      <= '0;
      pwm_cnt    <= '0;
      decay_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      led_q      <= led_in;
      pwm_cnt    <= pwm_cnt + P_ONE;
      frame_tick <= (pwm_cnt == MAX);
      decay_cnt  <= decay_tick ? '0 : decay_cnt + D_ONE;
    end
  end

  // Load beats decay; decay saturates at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (btn) begin
      for (int i = 0; i < N_LEDS; i++) begin
        bright[i] <= '0;
      end
      led_out <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (led_q[i]) begin
          bright[i] <= MAX;
        end else if (decay_tick) begin
          bright[i] <= (bright[i] < STEP) ? '0
                     : bright[i] - STEP;
        end
        led_out[i] <= (bright[i] == MAX)
                    | (bright[i] > pwm_cnt);
      end
    end
  end

endmodule
